// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the byte-stream program loader.
// Holds the FSM state encoding, the default frame marker and a state-class helper.
// No logic of its own; imported by prog_loader and its sub-module.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_LEN  = 3'd2,
    S_DATA = 3'd3,
    S_CSUM = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  // True while a frame is in progress and the idle timeout is armed.
  function automatic logic frame_active(input state_t s);
    return (s == S_ADDR) || (s == S_LEN) || (s == S_DATA) || (s == S_CSUM);
  endfunction

endpackage

// File: rtl/prog_loader_timeout.sv
// Idle-cycle counter for the loader: counts while enabled, clears on request.
// Latency: expire_o is combinational from the count and enable, no extra delay.
// Backpressure: none; the parent decides what an expiry means.
// Ports: clk, rst (async, active-high), clr_i (zero the count), en_i (count one
//   idle cycle), expire_o (count is at TIMEOUT-1 and another idle cycle is seen).
module loader_timeout #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: parses SYNC/ADDR/LEN/payload/CSUM frames into RAM writes.
// Latency: RAM write one cycle after each payload handshake; done/err one cycle after CSUM.
// Backpressure: in_ready low only in the one-cycle DONE/ERR states and during reset.
// Ports: clk, rst (async, active-high); in_valid/in_data/in_ready byte stream;
//   mem_we/mem_addr/mem_wdata RAM write port; cpu_hold CPU reset request;
//   load_done/load_err one-cycle result pulses.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int         ADDR_W    = 8,
  parameter int         TIMEOUT   = 1024,
  parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [7:0]        sum_q, sum_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              hold_q, hold_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [7:0]        wdata_q, wdata_d;

  logic hs;
  logic in_frame;
  logic tmo_expire;

  // Gated with rst so the stream sees not-ready while reset is held.
  assign in_ready = !rst && (state_q != S_DONE) && (state_q != S_ERR);
  assign hs       = in_valid && in_ready;
  assign in_frame = frame_active(state_q);

  loader_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (!in_frame || hs),
    .en_i     (in_frame && !hs),
    .expire_o (tmo_expire)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (hs && (in_data == SYNC_BYTE)) begin
          state_d = S_ADDR;
          hold_d  = 1'b1;
        end
      end
      S_ADDR: begin
        if (hs) begin
          ptr_d   = ADDR_W'(in_data);
          sum_d   = in_data;
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (hs) begin
          cnt_d   = in_data;
          sum_d   = sum_q + in_data;
          state_d = (in_data != 8'd0) ? S_DATA : S_CSUM;
        end
      end
      S_DATA: begin
        if (hs) begin
          we_d    = 1'b1;
          waddr_d = ptr_q;
          wdata_d = in_data;
          ptr_d   = ptr_q + ADDR_W'(1);
          sum_d   = sum_q + in_data;
          cnt_d   = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            state_d = S_CSUM;
          end
        end
      end
      S_CSUM: begin
        if (hs) begin
          if (in_data == sum_q) begin
            state_d = S_DONE;
            // Cleared on entry so the CPU is released in the DONE cycle itself.
            hold_d  = 1'b0;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Expiry only fires in a cycle with no handshake, so nothing above changed.
    if (tmo_expire) begin
      state_d = S_ERR;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      hold_q  <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = waddr_q;
  assign mem_wdata = wdata_q;
  assign cpu_hold  = hold_q;
  assign load_done = (state_q == S_DONE);
  assign load_err  = (state_q == S_ERR);

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frame vectors from a table plus timeout, reset and
// randomized-gap sequences. Expected writes and checksums are hand-derived; the
// checksum covers ADDR, LEN and every payload byte, modulo 256.
module tb_prog_loader;

  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_hold;
  logic       load_done;
  logic       load_err;

  prog_loader #(
    .ADDR_W    (8),
    .TIMEOUT   (TMO),
    .SYNC_BYTE (8'hA5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  // Write / pulse monitor, sampled on the falling edge.
  logic [15:0] wq[$];
  int done_cnt = 0;
  int err_cnt  = 0;
  always @(negedge clk) begin
    if (mem_we)    wq.push_back({mem_addr, mem_wdata});
    if (load_done) done_cnt++;
    if (load_err)  err_cnt++;
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Called just after a falling edge; returns on the falling edge after the handshake.
  task automatic send(input logic [7:0] b);
    int guard;
    in_valid = 1'b1;
    in_data  = b;
    guard    = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) chk("ready_wait", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_gap(input logic [7:0] b);
    repeat ($urandom_range(0, 1)) @(negedge clk);
    send(b);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct packed {
    logic [3:0]  n;
    logic [79:0] by;    // frame bytes, first byte leftmost
    logic [2:0]  nw;
    logic [31:0] wa;    // expected write addresses, first leftmost
    logic [31:0] wd;    // expected write data, first leftmost
    logic        done;
    logic        err;
    logic        hold;
  } vec_t;

  function automatic vec_t mk(input int n, input logic [79:0] by, input int nw,
                              input logic [31:0] wa, input logic [31:0] wd,
                              input logic done, input logic err, input logic hold);
    vec_t v;
    v.n = 4'(n); v.by = by; v.nw = 3'(nw); v.wa = wa; v.wd = wd;
    v.done = done; v.err = err; v.hold = hold;
    return v;
  endfunction

  localparam int NV = 6;
  vec_t vecs[NV];

  int          base_w, base_d, base_e;
  logic [7:0]  ra, rsum;
  logic [7:0]  pay [6];

  initial begin
    vecs[0] = mk(7, {8'hA5,8'h10,8'h03,8'h11,8'h22,8'h33,8'h79}, 3,
                 {8'h10,8'h11,8'h12}, {8'h11,8'h22,8'h33}, 1'b1, 1'b0, 1'b0);
    vecs[1] = mk(7, {8'hA5,8'h10,8'h03,8'h11,8'h22,8'h33,8'h7A}, 3,
                 {8'h10,8'h11,8'h12}, {8'h11,8'h22,8'h33}, 1'b0, 1'b1, 1'b1);
    vecs[2] = mk(4, {8'hA5,8'h00,8'h00,8'h00}, 0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    vecs[3] = mk(7, {8'hA5,8'hFE,8'h03,8'h01,8'h02,8'h03,8'h07}, 3,
                 {8'hFE,8'hFF,8'h00}, {8'h01,8'h02,8'h03}, 1'b1, 1'b0, 1'b0);
    // Leading junk byte dropped in IDLE; embedded A5 is plain payload.
    vecs[4] = mk(7, {8'h00,8'hA5,8'h40,8'h02,8'hA5,8'h5A,8'h41}, 2,
                 {8'h40,8'h41}, {8'hA5,8'h5A}, 1'b1, 1'b0, 1'b0);
    vecs[5] = mk(5, {8'hA5,8'h80,8'h01,8'hC3,8'h45}, 1,
                 {8'h80}, {8'hC3}, 1'b0, 1'b1, 1'b1);

    // Reset state while rst is held.
    #12;
    chk("rst_in_ready", 32'(in_ready),  32'd0);
    chk("rst_mem_we",   32'(mem_we),    32'd0);
    chk("rst_mem_addr", 32'(mem_addr),  32'd0);
    chk("rst_wdata",    32'(mem_wdata), 32'd0);
    chk("rst_hold",     32'(cpu_hold),  32'd0);
    chk("rst_done",     32'(load_done), 32'd0);
    chk("rst_err",      32'(load_err),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    // Table-driven frames.
    for (int i = 0; i < NV; i++) begin
      base_w = wq.size(); base_d = done_cnt; base_e = err_cnt;
      for (int j = 0; j < int'(vecs[i].n); j++)
        send(vecs[i].by[8*(int'(vecs[i].n)-1-j) +: 8]);
      idle(3);
      chk($sformatf("v%0d_nwrites", i), 32'(wq.size() - base_w), 32'(vecs[i].nw));
      for (int k = 0; k < int'(vecs[i].nw); k++) begin
        if (base_w + k < wq.size()) begin
          chk($sformatf("v%0d_waddr%0d", i, k), 32'(wq[base_w+k][15:8]),
              32'(vecs[i].wa[8*(int'(vecs[i].nw)-1-k) +: 8]));
          chk($sformatf("v%0d_wdata%0d", i, k), 32'(wq[base_w+k][7:0]),
              32'(vecs[i].wd[8*(int'(vecs[i].nw)-1-k) +: 8]));
        end
      end
      chk($sformatf("v%0d_done", i), 32'(done_cnt - base_d), 32'(vecs[i].done));
      chk($sformatf("v%0d_err", i),  32'(err_cnt - base_e),  32'(vecs[i].err));
      chk($sformatf("v%0d_hold", i), 32'(cpu_hold),          32'(vecs[i].hold));
    end

    // Timeout: A5,20 then TMO idle cycles.
    base_w = wq.size(); base_e = err_cnt;
    send(8'hA5);
    chk("tmo_hold_set", 32'(cpu_hold), 32'd1);
    send(8'h20);
    idle(TMO - 1);
    chk("tmo_not_yet", 32'(load_err), 32'd0);
    idle(1);
    chk("tmo_err_pulse", 32'(load_err), 32'd1);
    chk("tmo_err_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    send(8'h00);
    idle(3);
    chk("tmo_err_count", 32'(err_cnt - base_e), 32'd1);
    chk("tmo_no_write",  32'(wq.size() - base_w), 32'd0);
    chk("tmo_hold_kept", 32'(cpu_hold), 32'd1);

    // A handshake in the last allowed idle cycle beats the timeout.
    base_d = done_cnt; base_e = err_cnt;
    send(8'hA5);
    idle(TMO - 1);
    send(8'h30);
    send(8'h00);
    send(8'h30);
    idle(3);
    chk("edge_done", 32'(done_cnt - base_d), 32'd1);
    chk("edge_err",  32'(err_cnt - base_e),  32'd0);
    chk("edge_hold", 32'(cpu_hold), 32'd0);

    // Asynchronous reset in the middle of the payload.
    send(8'hA5); send(8'h50); send(8'h04); send(8'h01); send(8'h02);
    chk("mid_we_before", 32'(mem_we), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_we",    32'(mem_we),    32'd0);
    chk("mid_addr",  32'(mem_addr),  32'd0);
    chk("mid_wdata", 32'(mem_wdata), 32'd0);
    chk("mid_hold",  32'(cpu_hold),  32'd0);
    chk("mid_ready", 32'(in_ready),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    base_w = wq.size(); base_d = done_cnt;
    send(8'hA5); send(8'h60); send(8'h01); send(8'h77); send(8'hD8);
    idle(3);
    chk("post_rst_nwr", 32'(wq.size() - base_w), 32'd1);
    if (wq.size() > base_w) chk("post_rst_write", 32'(wq[base_w]), 32'h6077);
    chk("post_rst_done", 32'(done_cnt - base_d), 32'd1);

    // Random idle gaps, payload with an embedded sync byte.
    for (int r = 0; r < 3; r++) begin
      ra = 8'($urandom_range(0, 255));
      rsum = ra + 8'd6;
      for (int k = 0; k < 6; k++) begin
        pay[k] = (k == 2) ? 8'hA5 : 8'($urandom_range(0, 255));
        rsum = rsum + pay[k];
      end
      base_w = wq.size(); base_d = done_cnt; base_e = err_cnt;
      send_gap(8'hA5); send_gap(ra); send_gap(8'd6);
      for (int k = 0; k < 6; k++) send_gap(pay[k]);
      send_gap(rsum);
      idle(3);
      chk($sformatf("rnd%0d_nwr", r), 32'(wq.size() - base_w), 32'd6);
      for (int k = 0; k < 6; k++)
        if (base_w + k < wq.size())
          chk($sformatf("rnd%0d_w%0d", r, k), 32'(wq[base_w+k]),
              32'({8'(ra + 8'(k)), pay[k]}));
      chk($sformatf("rnd%0d_done", r), 32'(done_cnt - base_d), 32'd1);
      chk($sformatf("rnd%0d_err", r),  32'(err_cnt - base_e),  32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

endmodule
